// File: rtl/taxi_axis_frame_len_limit_if.sv
// AXI4-Stream interface bundle shared by stream sources and sinks.
// Optional sideband (keep/last/id/dest/user) is always present as wires;
// the *_EN parameters tell consumers whether the field carries meaning.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = (DATA_W > 8),
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter bit LAST_EN = 1'b1,
    parameter bit ID_EN   = 1'b0,
    parameter int ID_W    = 8,
    parameter bit DEST_EN = 1'b0,
    parameter int DEST_W  = 8,
    parameter bit USER_EN = 1'b0,
    parameter int USER_W  = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/taxi_axis_frame_len_limit.sv
// AXI4-Stream frame-length limiter. Zero-latency pass-through that counts
// beats per frame, cuts frames longer than max_len (forcing tlast and a
// tuser error bit on the last forwarded beat) and swallows the remainder.
// Reports the input length of every frame one cycle after its tlast beat.
// Optional: define TAXI_AXIS_FRAME_LEN_LIMIT_STATS_EN to enable the
// saturating truncated-frame counter on trunc_cnt (tied to 0 otherwise).
module taxi_axis_frame_len_limit #(
    parameter int LEN_W   = 16,
    parameter int ERR_BIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    taxi_axis_if.snk         s_axis,
    taxi_axis_if.src         m_axis,
    input  logic [LEN_W-1:0] max_len,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_len_valid,
    output logic             frame_trunc,
    output logic [15:0]      trunc_cnt
);
    localparam bit LAST_EN = s_axis.LAST_EN;
    localparam bit USER_EN = s_axis.USER_EN;
    localparam int USER_W  = s_axis.USER_W;

    // Both sides must describe the same stream; there is no width adaptation.
    if (s_axis.DATA_W != m_axis.DATA_W || s_axis.KEEP_EN != m_axis.KEEP_EN ||
        s_axis.KEEP_W != m_axis.KEEP_W || s_axis.LAST_EN != m_axis.LAST_EN ||
        s_axis.ID_EN != m_axis.ID_EN || s_axis.ID_W != m_axis.ID_W ||
        s_axis.DEST_EN != m_axis.DEST_EN || s_axis.DEST_W != m_axis.DEST_W ||
        s_axis.USER_EN != m_axis.USER_EN || s_axis.USER_W != m_axis.USER_W) begin : g_param_chk
        $fatal(1, "taxi_axis_frame_len_limit: s_axis/m_axis interface parameters differ");
    end

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, lim;
    logic [LEN_W-1:0] beat_num, lim_eff;
    logic             beat, in_last, trunc_cond;

    // Without tlast every beat is its own frame, so the limit never bites.
    assign in_last  = LAST_EN ? s_axis.tlast : 1'b1;
    assign beat     = s_axis.tvalid && s_axis.tready;
    // Ordinal of the beat currently offered; counter saturates at all-ones.
    assign beat_num = (state == IDLE) ? LEN_W'(1) : ((cnt == '1) ? cnt : cnt + 1'b1);
    // First beat of a frame uses the live max_len, later beats the latched one.
    assign lim_eff  = (state == IDLE) ? max_len : lim;
    // Offered beat is the limit beat of a frame that continues past it.
    assign trunc_cond = (state != DROP) && (lim_eff != '0) && (beat_num == lim_eff) && !in_last;

    // Stream pass-through; DROP sinks the remainder without forwarding.
    assign m_axis.tvalid = (state != DROP) && s_axis.tvalid;
    assign s_axis.tready = (state == DROP) ? 1'b1 : m_axis.tready;
    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tkeep  = s_axis.tkeep;
    assign m_axis.tid    = s_axis.tid;
    assign m_axis.tdest  = s_axis.tdest;
    assign m_axis.tlast  = s_axis.tlast | trunc_cond;

    if (USER_EN && USER_W > ERR_BIT) begin : g_err_flag
        // Flag the cut-short final beat in tuser.
        always_comb begin
            m_axis.tuser = s_axis.tuser;
            if (trunc_cond) m_axis.tuser[ERR_BIT] = 1'b1;
        end
    end else begin : g_no_err_flag
        assign m_axis.tuser = s_axis.tuser;
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: end of frame wins, then truncation, then frame start.
    always_comb begin
        state_nxt = state;
        if (beat) begin
            if (in_last)             state_nxt = IDLE;
            else if (trunc_cond)     state_nxt = DROP;
            else if (state == IDLE)  state_nxt = PASS;
        end
    end

    // Beat counter, per-frame limit latch and end-of-frame status pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            lim             <= '0;
            frame_len       <= '0;
            frame_len_valid <= 1'b0;
            frame_trunc     <= 1'b0;
        end else begin
            frame_len_valid <= 1'b0;
            frame_trunc     <= 1'b0;
            if (beat) begin
                cnt <= beat_num;
                if (state == IDLE) lim <= max_len;
                if (in_last) begin
                    frame_len       <= beat_num;
                    frame_len_valid <= 1'b1;
                    frame_trunc     <= (state == DROP);
                end
            end
        end
    end

`ifdef TAXI_AXIS_FRAME_LEN_LIMIT_STATS_EN
    logic [15:0] trunc_cnt_q;

    // Count truncated frames alongside their frame_trunc pulse, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            trunc_cnt_q <= '0;
        else if (beat && in_last && state == DROP && trunc_cnt_q != 16'hFFFF)
            trunc_cnt_q <= trunc_cnt_q + 16'd1;
    end

    assign trunc_cnt = trunc_cnt_q;
`else
    assign trunc_cnt = 16'd0;
`endif
endmodule
